// File: rtl/histogram_readout_seq.sv
// Sweeps all histogram bins during vertical blanking, serialises scaled/saturated bin values
// onto the scope bus, sums raw counts, then pulses a single-cycle clear back to the histogram.
module histogram_readout_seq #(
    parameter int NUM_BINS = 1024,
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 16,
    parameter int OUT_W    = 10,
    parameter int SHIFT    = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_valid,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [CNT_W-1:0]          rd_data,
    output logic                      clear,
    output logic [OUT_W-1:0]          histo_data,
    output logic                      histo_valid,
    output logic                      histo_clock,
    output logic                      busy,
    output logic [CNT_W+ADDR_W-1:0]   total_count,
    output logic                      total_valid,
    output logic                      overrun,
    output logic [1:0]                state_o
);

    localparam int ACC_W = CNT_W + ADDR_W;
    localparam int WIDE  = (CNT_W > OUT_W) ? CNT_W : OUT_W;
    localparam logic [WIDE-1:0]   OUT_MAX  = WIDE'({OUT_W{1'b1}});
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t              state_q;
    logic                fv_q;
    logic                phase_q;
    logic                drain_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                clear_q;
    logic [OUT_W-1:0]    histo_data_q;
    logic                histo_valid_q;
    logic                histo_clock_q;
    logic                busy_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    total_count_q;
    logic                total_valid_q;
    logic                overrun_q;

    logic                fv_fall;
    logic                fv_rise;
    logic [WIDE-1:0]     shifted;
    logic [OUT_W-1:0]    scaled_d;
    logic [ACC_W-1:0]    acc_d;
    logic [ADDR_W-1:0]   rd_addr_d;

    assign fv_fall = fv_q & ~frame_valid;
    assign fv_rise = ~fv_q & frame_valid;

    always_comb begin
        shifted   = WIDE'(rd_data) >> SHIFT;
        scaled_d  = (shifted > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
        acc_d     = acc_q + ACC_W'(rd_data);
        rd_addr_d = rd_addr_q + 1'b1;
    end

    // Each bin spends two cycles in READ: phase 0 presents the address, phase 1 captures the
    // returned count. The drain pass keeps the last bin on the bus for its second half.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            fv_q          <= 1'b0;
            phase_q       <= 1'b0;
            drain_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            clear_q       <= 1'b0;
            histo_data_q  <= '0;
            histo_valid_q <= 1'b0;
            histo_clock_q <= 1'b0;
            busy_q        <= 1'b0;
            acc_q         <= '0;
            total_count_q <= '0;
            total_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            fv_q <= frame_valid;
            if (fv_rise && busy_q) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (fv_fall) begin
                        state_q   <= S_READ;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        phase_q   <= 1'b0;
                        drain_q   <= 1'b0;
                        acc_q     <= '0;
                    end
                end

                S_READ: begin
                    if (!phase_q) begin
                        phase_q       <= 1'b1;
                        // Rising strobe lands mid-way through the data eye of the held bin.
                        histo_clock_q <= histo_valid_q;
                    end else begin
                        phase_q <= 1'b0;
                        if (drain_q) begin
                            histo_valid_q <= 1'b0;
                            histo_data_q  <= '0;
                            histo_clock_q <= 1'b0;
                            clear_q       <= 1'b1;
                            total_count_q <= acc_q;
                            total_valid_q <= 1'b1;
                            state_q       <= S_CLEAR;
                        end else begin
                            histo_data_q  <= scaled_d;
                            histo_valid_q <= 1'b1;
                            histo_clock_q <= 1'b0;
                            acc_q         <= acc_d;
                            if (rd_addr_q == LAST_BIN) begin
                                drain_q   <= 1'b1;
                                rd_en_q   <= 1'b0;
                                rd_addr_q <= '0;
                            end else begin
                                rd_addr_q <= rd_addr_d;
                            end
                        end
                    end
                end

                S_CLEAR: begin
                    clear_q       <= 1'b0;
                    total_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign clear       = clear_q;
    assign histo_data  = histo_data_q;
    assign histo_valid = histo_valid_q;
    assign histo_clock = histo_clock_q;
    assign busy        = busy_q;
    assign total_count = total_count_q;
    assign total_valid = total_valid_q;
    assign overrun     = overrun_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_histogram_readout_seq.sv
// Bench for histogram_readout_seq: a table of sweep patterns checked cycle by cycle against
// a timing model derived from bin index arithmetic, plus hand-written reset sequences.
module tb_histogram_readout_seq;

    localparam int NUM_BINS = 1024;
    localparam int ADDR_W   = 10;
    localparam int CNT_W    = 16;
    localparam int OUT_W    = 10;
    localparam int SHIFT    = 6;
    localparam int TOT_W    = CNT_W + ADDR_W;

    logic               clk;
    logic               reset_n;
    logic               frame_valid;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [CNT_W-1:0]   rd_data;
    logic               clear;
    logic [OUT_W-1:0]   histo_data;
    logic               histo_valid;
    logic               histo_clock;
    logic               busy;
    logic [TOT_W-1:0]   total_count;
    logic               total_valid;
    logic               overrun;
    logic [1:0]         state_o;

    histogram_readout_seq #(
        .NUM_BINS(NUM_BINS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .clear(clear), .histo_data(histo_data), .histo_valid(histo_valid),
        .histo_clock(histo_clock), .busy(busy), .total_count(total_count),
        .total_valid(total_valid), .overrun(overrun), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Histogram memory model: one-cycle read latency.
    logic [CNT_W-1:0] mem [NUM_BINS];
    initial rd_data = '0;
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int errors = 0;
    int checks = 0;
    int sweep_bad;
    longint prev_total = 0;
    bit ovr_exp = 1'b0;
    logic [OUT_W-1:0] exp_q[$];

    typedef struct {
        int     pattern;
        bit     has_const;
        longint exp_total;
        int     exp_bin0;
        int     exp_binlast;
        int     rise_bin;
        int     fall_bin;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic cmp_cyc(input string name, input longint got, input longint exp, input int rel);
        if (got != exp) begin
            if (sweep_bad == 0)
                $display("  first divergence: %s at cycle T+%0d got %0d want %0d", name, rel, got, exp);
            sweep_bad++;
        end
    endtask

    function automatic int scale(input longint v);
        longint s;
        s = v / (64'd1 << SHIFT);
        if (s > (64'd1 << OUT_W) - 1) s = (64'd1 << OUT_W) - 1;
        return int'(s);
    endfunction

    task automatic fill_mem(input int pattern);
        for (int k = 0; k < NUM_BINS; k++) begin
            case (pattern)
                0: mem[k] = CNT_W'(k * 64);
                1: mem[k] = 16'hFFFF;
                2: mem[k] = 16'd63;
                default: mem[k] = CNT_W'($urandom_range(0, 65535));
            endcase
        end
    endtask

    task automatic fall_trigger();
        @(negedge clk); frame_valid = 1'b1;
        @(negedge clk); frame_valid = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input vec_t v);
        longint model_total;
        longint exp_tot_now;
        int edges, clears, tvs, first_d, last_d;
        logic prev_clk;
        bit e_valid, e_ovr;
        int e_data;
        logic [OUT_W-1:0] d;

        fill_mem(v.pattern);
        model_total = 0;
        exp_q.delete();
        for (int k = 0; k < NUM_BINS; k++) begin
            model_total += longint'(mem[k]);
            exp_q.push_back(OUT_W'(scale(longint'(mem[k]))));
        end
        sweep_bad = 0; edges = 0; clears = 0; tvs = 0; first_d = -1; last_d = -1;
        prev_clk = 1'b0;

        fall_trigger();
        for (int rel = 0; rel < 2 * NUM_BINS + 8; rel++) begin
            @(negedge clk);
            e_valid = (rel >= 2) && (rel <= 2 * NUM_BINS + 1);
            e_data  = e_valid ? scale(longint'(mem[(rel - 2) / 2])) : 0;
            e_ovr   = ovr_exp || (v.rise_bin >= 0 && rel > 2 * v.rise_bin);
            exp_tot_now = (rel >= 2 * NUM_BINS + 2) ? model_total : prev_total;
            cmp_cyc("busy", busy, (rel <= 2 * NUM_BINS + 2) ? 1 : 0, rel);
            cmp_cyc("rd_en", rd_en, (rel < 2 * NUM_BINS) ? 1 : 0, rel);
            if (rel < 2 * NUM_BINS) cmp_cyc("rd_addr", rd_addr, rel / 2, rel);
            cmp_cyc("histo_valid", histo_valid, e_valid ? 1 : 0, rel);
            cmp_cyc("histo_clock", histo_clock, (e_valid && (rel % 2 == 1)) ? 1 : 0, rel);
            cmp_cyc("histo_data", histo_data, e_data, rel);
            cmp_cyc("clear", clear, (rel == 2 * NUM_BINS + 2) ? 1 : 0, rel);
            cmp_cyc("total_valid", total_valid, (rel == 2 * NUM_BINS + 2) ? 1 : 0, rel);
            cmp_cyc("total_count", total_count, exp_tot_now, rel);
            cmp_cyc("overrun", overrun, e_ovr ? 1 : 0, rel);
            if (clear) clears++;
            if (total_valid) tvs++;
            if (!prev_clk && histo_clock) begin
                edges++;
                if (exp_q.size() == 0) begin
                    cmp_cyc("extra_strobe", 1, 0, rel);
                end else begin
                    d = exp_q.pop_front();
                    cmp_cyc("strobe_data", histo_data, d, rel);
                    if (first_d < 0) first_d = histo_data;
                    last_d = histo_data;
                end
            end
            prev_clk = histo_clock;
            if (v.rise_bin >= 0 && rel == 2 * v.rise_bin) frame_valid = 1'b1;
            if (v.fall_bin >= 0 && rel == 2 * v.fall_bin) frame_valid = 1'b0;
        end

        check({tag, " cycle_trace"}, sweep_bad, 0);
        check({tag, " strobe_edges"}, edges, NUM_BINS);
        check({tag, " clear_pulses"}, clears, 1);
        check({tag, " total_valid_pulses"}, tvs, 1);
        check({tag, " total_vs_model"}, total_count, model_total);
        if (v.has_const) begin
            check({tag, " total_const"}, total_count, v.exp_total);
            check({tag, " bin0_data"}, first_d, v.exp_bin0);
            check({tag, " binlast_data"}, last_d, v.exp_binlast);
        end
        check({tag, " queue_drained"}, exp_q.size(), 0);
        check({tag, " overrun_final"}, overrun, (ovr_exp || v.rise_bin >= 0) ? 1 : 0);
        prev_total = model_total;
        ovr_exp = ovr_exp || (v.rise_bin >= 0);
    endtask

    task automatic reset_mid_sweep();
        int bad;
        fill_mem(0);
        fall_trigger();
        for (int rel = 0; rel <= 1000; rel++) @(negedge clk);
        check("mid rd_addr_at_bin500", rd_addr, 500);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid rst rd_en", rd_en, 0);
        check("mid rst histo_valid", histo_valid, 0);
        check("mid rst histo_data", histo_data, 0);
        check("mid rst busy", busy, 0);
        check("mid rst total_count", total_count, 0);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clear || busy || total_valid || rd_en) bad++;
        end
        check("mid post_reset_quiet", bad, 0);
        prev_total = 0;
        ovr_exp = 1'b0;
    endtask

    initial begin
        int bad;
        vecs[0] = '{0, 1'b1, 64'd33521664, 0,    1023, -1,  -1};
        vecs[1] = '{1, 1'b1, 64'd67107840, 1023, 1023, -1,  -1};
        vecs[2] = '{2, 1'b1, 64'd64512,    0,    0,    -1,  -1};
        vecs[3] = '{0, 1'b1, 64'd33521664, 0,    1023, 300, 600};
        vecs[4] = '{3, 1'b0, 64'd0,        0,    0,    -1,  -1};

        reset_n = 1'b0;
        frame_valid = 1'b0;
        fill_mem(0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            frame_valid = ~frame_valid;
            if (rd_en || rd_addr != 0 || clear || histo_data != 0 || histo_valid || histo_clock ||
                busy || total_count != 0 || total_valid || overrun || state_o != 0) bad++;
        end
        check("reset outputs_zero", bad, 0);
        @(negedge clk);
        frame_valid = 1'b0;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || rd_en || clear || histo_valid) bad++;
        end
        check("reset no_sweep_when_low", bad, 0);

        for (int i = 0; i < 5; i++) begin
            if (i == 3) reset_mid_sweep();
            run_sweep($sformatf("vec%0d", i), vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
